// File: rtl/cpu6_ifid_queue.sv
// Fetch-to-decode instruction queue: circular buffer presenting the oldest
// fetched (pc, instr) to decode, flushed in one cycle on flash or reset.
module cpu6_ifid_queue #(
    parameter int CPU6_XLEN = 32,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flash,
    input  logic                 stallD,
    input  logic                 fvalid,
    input  logic [CPU6_XLEN-1:0] fpc,
    input  logic [CPU6_XLEN-1:0] finstr,
    output logic                 fready,
    output logic                 validD,
    output logic [CPU6_XLEN-1:0] pcD,
    output logic [CPU6_XLEN-1:0] instrD,
    output logic [CNT_W-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CPU6_XLEN-1:0] pc_mem_q    [DEPTH];
    logic [CPU6_XLEN-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic enq;
    logic deq;

    // Ready depends on occupancy only, so a full queue never accepts even
    // when the head drains in the same cycle.
    assign fready = (cnt_q != CNT_W'(DEPTH));
    assign validD = (cnt_q != '0);
    assign count  = cnt_q;

    assign enq = fvalid & fready & ~flash;
    assign deq = validD & ~stallD & ~flash;

    assign pcD    = validD ? pc_mem_q[rp_q]    : '0;
    assign instrD = validD ? instr_mem_q[rp_q] : '0;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (reset || flash) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            wp_d  = wp_q + PTR_W'(enq);
            rp_d  = rp_q + PTR_W'(deq);
            cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            pc_mem_q[wp_q]    <= fpc;
            instr_mem_q[wp_q] <= finstr;
        end
    end

endmodule

// File: tb/tb_cpu6_ifid_queue.sv
// Directed bench for cpu6_ifid_queue: reset, pass-through, stall fill,
// streaming with pointer wrap, flash and reset-while-full.
module tb_cpu6_ifid_queue;

    logic        clk;
    logic        reset;
    logic        flash;
    logic        stallD;
    logic        fvalid;
    logic [31:0] fpc;
    logic [31:0] finstr;
    logic        fready;
    logic        validD;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic [1:0]  count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cpu6_ifid_queue #(
        .CPU6_XLEN (32),
        .DEPTH     (2),
        .CNT_W     (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .flash  (flash),
        .stallD (stallD),
        .fvalid (fvalid),
        .fpc    (fpc),
        .finstr (finstr),
        .fready (fready),
        .validD (validD),
        .pcD    (pcD),
        .instrD (instrD),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flash = 1'b0; stallD = 1'b0; fvalid = 1'b0;
        fpc = '0; finstr = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_validD", 32'(validD), 32'd0);
        check("rst_pcD",    pcD,         32'h0);
        check("rst_instrD", instrD,      32'h0);
        check("rst_count",  32'(count),  32'd0);
        check("rst_fready", 32'(fready), 32'd1);

        // Single pass
        fvalid = 1'b1; fpc = 32'h100; finstr = 32'h13;
        step();
        fvalid = 1'b0;
        check("pass_validD", 32'(validD), 32'd1);
        check("pass_pcD",    pcD,         32'h100);
        check("pass_instrD", instrD,      32'h13);
        check("pass_count",  32'(count),  32'd1);
        step();
        check("pass_drain_validD", 32'(validD), 32'd0);
        check("pass_drain_count",  32'(count),  32'd0);
        check("pass_drain_pcD",    pcD,         32'h0);

        // Stall fill
        stallD = 1'b1;
        fvalid = 1'b1; fpc = 32'h100; finstr = 32'hA100;
        step();
        check("fill1_count", 32'(count), 32'd1);
        check("fill1_pcD",   pcD,        32'h100);
        fpc = 32'h104; finstr = 32'hA104;
        step();
        check("fill2_count",  32'(count),  32'd2);
        check("fill2_fready", 32'(fready), 32'd0);
        check("fill2_pcD",    pcD,         32'h100);
        fpc = 32'h108; finstr = 32'hA108;
        step();
        check("fill3_count", 32'(count), 32'd2);
        check("fill3_pcD",   pcD,        32'h100);
        fvalid = 1'b0;
        step();
        check("hold_pcD",    pcD,    32'h100);
        check("hold_instrD", instrD, 32'hA100);
        // Release while full with a new fetch pending: it must wait a cycle.
        stallD = 1'b0; fvalid = 1'b1; fpc = 32'h10C; finstr = 32'hA10C;
        check("rel_pcD", pcD, 32'h100);
        step();
        check("rel1_pcD",    pcD,        32'h104);
        check("rel1_instrD", instrD,     32'hA104);
        check("rel1_count",  32'(count), 32'd1);
        step();
        fvalid = 1'b0;
        check("rel2_pcD",   pcD,        32'h10C);
        check("rel2_count", 32'(count), 32'd1);
        step();
        check("rel3_validD", 32'(validD), 32'd0);
        check("rel3_count",  32'(count),  32'd0);

        // Streaming with pointer wrap
        for (int i = 0; i < 8; i++) begin
            fvalid = 1'b1; fpc = 32'h200 + 32'(4 * i); finstr = 32'h1000 + 32'(i);
            step();
            check($sformatf("stream%0d_pcD", i),    pcD,        32'h200 + 32'(4 * i));
            check($sformatf("stream%0d_instrD", i), instrD,     32'h1000 + 32'(i));
            check($sformatf("stream%0d_count", i),  32'(count), 32'd1);
        end
        fvalid = 1'b0;
        step();
        check("stream_end_count", 32'(count), 32'd0);

        // Flash while full and stalled, with a fetch in the same cycle
        stallD = 1'b1;
        fvalid = 1'b1; fpc = 32'h300; finstr = 32'hB300;
        step();
        fpc = 32'h304; finstr = 32'hB304;
        step();
        check("fl_full_count",  32'(count),  32'd2);
        check("fl_full_fready", 32'(fready), 32'd0);
        flash = 1'b1; fpc = 32'h400; finstr = 32'hB400;
        step();
        flash = 1'b0; fvalid = 1'b0;
        check("fl_count",  32'(count),  32'd0);
        check("fl_validD", 32'(validD), 32'd0);
        check("fl_pcD",    pcD,         32'h0);
        check("fl_fready", 32'(fready), 32'd1);
        stallD = 1'b0; fvalid = 1'b1; fpc = 32'h500; finstr = 32'hB500;
        step();
        fvalid = 1'b0;
        check("fl_next_pcD",   pcD,        32'h500);
        check("fl_next_count", 32'(count), 32'd1);
        step();
        check("fl_drain_validD", 32'(validD), 32'd0);
        check("fl_drain_pcD",    pcD,         32'h0);

        // Reset with flash while full and stalled
        stallD = 1'b1;
        fvalid = 1'b1; fpc = 32'h700; finstr = 32'hC700;
        step();
        fpc = 32'h704; finstr = 32'hC704;
        step();
        check("rf_full_count", 32'(count), 32'd2);
        reset = 1'b1; flash = 1'b1; fpc = 32'h708; finstr = 32'hC708;
        step();
        reset = 1'b0; flash = 1'b0; fvalid = 1'b0;
        check("rf_count",  32'(count),  32'd0);
        check("rf_fready", 32'(fready), 32'd1);
        check("rf_validD", 32'(validD), 32'd0);
        check("rf_pcD",    pcD,         32'h0);
        stallD = 1'b0; fvalid = 1'b1; fpc = 32'h600; finstr = 32'hC600;
        step();
        fvalid = 1'b0;
        check("rf_next_pcD",    pcD,        32'h600);
        check("rf_next_instrD", instrD,     32'hC600);
        check("rf_next_count",  32'(count), 32'd1);
        step();
        check("rf_drain_validD", 32'(validD), 32'd0);
        check("rf_drain_count",  32'(count),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu6_ifid_queue.md
Name: cpu6_ifid_queue

Overview:
- Fetch-to-decode buffering stage: a small instruction queue between the fetch unit and the decode stage.
- Decode output feeds the ID/EX pipeline register.
- Absorbs fetch responses while decode is stalled and presents the oldest instruction (pc, instr, valid) to decode.
- Drops all contents on flash (taken branch/jump redirect from EX).

Parameters:
- CPU6_XLEN, 32: width of pc and instruction words.
- DEPTH, 2: queue entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flash  input  1  kill all queued and incoming instructions this cycle.
- stallD  input  1  decode cannot accept its current instruction this cycle.
- fvalid  input  1  fetch presents a valid instruction.
- fpc  input  CPU6_XLEN  pc of the fetched instruction.
- finstr  input  CPU6_XLEN  fetched instruction word.
- fready  output  1  queue can accept an entry this cycle.
- validD  output  1  head entry valid for decode.
- pcD  output  CPU6_XLEN  head pc.
- instrD  output  CPU6_XLEN  head instruction.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Circular buffer: write pointer wp, read pointer rp (log2(DEPTH) bits each, wrap modulo DEPTH), occupancy register cnt. count = cnt.
- Enqueue (enq) = fvalid & fready & ~flash. Writes {fpc, finstr} at wp; wp increments.
- Dequeue (deq) = validD & ~stallD & ~flash. rp increments.
- fready = (cnt != DEPTH). Combinational from state only; never depends on stallD or fvalid.
  - A full queue refuses an enqueue even when a dequeue happens the same cycle.
- validD = (cnt != 0).
- pcD/instrD:
  - When validD = 1: entry at rp.
  - When validD = 0: forced to all-zero (zero-masked, same as a flushed pipeline slot).
- No bypass: an entry enqueued at edge N is first visible on pcD/instrD after edge N (cycle N+1). Minimum fetch-to-decode latency is 1 cycle.
- Occupancy update:
  - cnt_next = cnt + enq − deq.
  - Simultaneous enq and deq with 0 < cnt < DEPTH leaves cnt unchanged; both pointers advance.
- Boundaries:
  - Empty with stallD = 1: no dequeue; outputs stay zero.
  - Full with stallD = 1: fready = 0; head held stable for as many cycles as the stall lasts.
  - Pointer wrap from DEPTH−1 to 0 must keep FIFO order.
- flash (synchronous):
  - Next state is cnt = 0, wp = rp = 0, with validD = 0 and pcD/instrD = 0 from the next cycle.
  - An fvalid arriving in the flash cycle is discarded.
  - The head is not considered consumed in the flash cycle.
  - Storage contents need not be cleared.
- reset: same next state as flash, and all outputs zero after the edge (fready = 1 after reset). Reset has priority over flash; flash has priority over enq/deq.
- Reset or flash asserted while full and stalled: the queue empties in one cycle regardless of stallD.
- Storage array may be non-reset flops; only cnt, wp, rp are reset.

Test Plan:
- Reset then idle → validD = 0, pcD = 0, instrD = 0, count = 0, fready = 1.
- Single pass: fvalid = 1, fpc = 0x0000_0100, finstr = 0x0000_0013 for one cycle, stallD = 0 → next cycle validD = 1, pcD = 0x100, instrD = 0x13; the following cycle validD = 0, count = 0.
- Stall fill:
  - stallD = 1; enqueue pcs 0x100, 0x104 → count = 2, fready = 0; third fvalid (pc 0x108) is not accepted.
  - Head stays 0x100 throughout the stall.
  - Release stallD → decode sees 0x100 then 0x104 on consecutive cycles.
- Streaming: fvalid every cycle, pcs 0x200, 0x204, …, 0x21C, stallD = 0 → pcD shows each pc exactly once, one cycle after issue. count holds at 1; wp/rp wrap at least 4 times with order intact.
- Flash:
  - Queue full (0x300, 0x304), stallD = 1.
  - Assert flash together with fvalid (pc 0x400) → next cycle count = 0, validD = 0, pcD = 0; 0x400 is never presented.
  - Enqueue 0x500 the cycle after → it appears next.
- Reset while full and stalled, with flash = 1 the same cycle → after the edge count = 0, fready = 1, validD = 0; no stale entry reappears after fetching 0x600.
